// File: rtl/if_share_arbiter_if.sv
// Shared valid/ready channel bundle: NREQ requester lanes in, one shared lane out.
// The master view is the arbiter; the slave view is the requesters and the sink.
interface if_share_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_last;
  logic [NREQ-1:0]    req_ready;
  logic               out_valid;
  logic [DW-1:0]      out_data;
  logic               out_last;
  logic               out_ready;

  modport master (
    input  req_valid, req_data, req_last, out_ready,
    output req_ready, out_valid, out_data, out_last
  );

  modport slave (
    output req_valid, req_data, req_last, out_ready,
    input  req_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/if_share_arbiter.sv
// Round-robin arbiter sharing one valid/ready channel among NREQ requesters.
// Grant is held until a packet end or until MAXBURST beats have been accepted.
//
// state | meaning
// IDLE  | no grant held; arbitrate among valid requesters
// GRANT | grant_id owns the shared channel; beats pass through combinationally
module if_share_arbiter #(
  parameter int NREQ     = 4,
  parameter int DW       = 8,
  parameter int MAXBURST = 4,
  localparam int GW      = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  if_share_arbiter_if.master   bus,
  output logic [GW-1:0]        grant_id,
  output logic                 busy
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;
  localparam logic [7:0] MAXB  = 8'(MAXBURST);

  logic [0:0]      state;
  logic [GW-1:0]   rr_last;
  logic [7:0]      beats;
  logic [GW-1:0]   pick;
  logic            found;
  int              idx;
  logic [NREQ-1:0] rdy;
  logic            ovalid;
  logic [DW-1:0]   odata;
  logic            olast;
  logic            hs;
  logic            rel;

  // Cyclic search starting just after the most recent grant.
  always_comb begin
    pick  = rr_last;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(rr_last) + k) % NREQ;
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        pick  = GW'(idx);
      end
    end
  end

  always_comb begin
    ovalid = 1'b0;
    odata  = '0;
    olast  = 1'b0;
    rdy    = '0;
    if (state == GRANT) begin
      ovalid        = bus.req_valid[grant_id];
      odata         = bus.req_data[grant_id*DW +: DW];
      olast         = bus.req_last[grant_id];
      rdy[grant_id] = bus.out_ready;
    end
  end

  assign bus.out_valid = ovalid;
  assign bus.out_data  = odata;
  assign bus.out_last  = olast;
  assign bus.req_ready = rdy;
  assign busy          = (state == GRANT);

  assign hs  = ovalid && bus.out_ready;
  assign rel = hs && (olast || (beats + 8'd1 == MAXB));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant_id <= '0;
      rr_last  <= GW'(NREQ - 1);
      beats    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant_id <= pick;
            rr_last  <= pick;
            beats    <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (hs) beats <= beats + 8'd1;
          if (rel) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_share_arbiter.sv
// Directed bench for if_share_arbiter: a vector table for round-robin order,
// then hand-written sequences for packet hold, burst limit, stalls and reset.
module tb_if_share_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] grant_id;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  if_share_arbiter_if #(.NREQ(4), .DW(8)) bus ();

  if_share_arbiter #(.NREQ(4), .DW(8), .MAXBURST(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  rv;
    logic [3:0]  rl;
    logic [31:0] rd;
    logic        ordy;
    logic        ebusy;
    logic [1:0]  egid;
    logic        eov;
    logic [7:0]  eod;
    logic        eol;
    logic [3:0]  err;
  } vec_t;

  vec_t vt [11];

  logic [1:0] exp_bg [12] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0};
  logic [7:0] exp_bd [12] = '{8'h50, 8'h51, 8'h52, 8'h53, 8'hF0, 8'h54, 8'h55, 8'h56, 8'h57, 8'hF0, 8'h58, 8'h59};
  logic [1:0] got_bg [12];
  logic [7:0] got_bd [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] rv, input logic [3:0] rl, input logic [31:0] rd,
                       input logic ordy);
    bus.req_valid = rv;
    bus.req_last  = rl;
    bus.req_data  = rd;
    bus.out_ready = ordy;
  endtask

  // Drive after the falling edge, sample 1 ns later; the rising edge follows.
  task automatic cyc(input logic [3:0] rv, input logic [3:0] rl, input logic [31:0] rd,
                     input logic ordy);
    @(negedge clk);
    drive(rv, rl, rd, ordy);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(4'h0, 4'h0, 32'h0, 1'b0);
    @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_gid", 32'(grant_id), 32'h0);
    chk("rst_ov", 32'(bus.out_valid), 32'h0);
    chk("rst_rr", 32'(bus.req_ready), 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int ng;
    logic [7:0] d0;

    vt[0]  = '{4'hF, 4'hF, 32'h44332211, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 4'h0};
    vt[1]  = '{4'hF, 4'hF, 32'h44332211, 1'b1, 1'b1, 2'd0, 1'b1, 8'h11, 1'b1, 4'h1};
    vt[2]  = '{4'hF, 4'hF, 32'h44332211, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 4'h0};
    vt[3]  = '{4'hF, 4'hF, 32'h44332211, 1'b1, 1'b1, 2'd1, 1'b1, 8'h22, 1'b1, 4'h2};
    vt[4]  = '{4'hF, 4'hF, 32'h44332211, 1'b1, 1'b0, 2'd1, 1'b0, 8'h00, 1'b0, 4'h0};
    vt[5]  = '{4'hF, 4'hF, 32'h44332211, 1'b1, 1'b1, 2'd2, 1'b1, 8'h33, 1'b1, 4'h4};
    vt[6]  = '{4'hF, 4'hF, 32'h44332211, 1'b1, 1'b0, 2'd2, 1'b0, 8'h00, 1'b0, 4'h0};
    vt[7]  = '{4'hF, 4'hF, 32'h44332211, 1'b1, 1'b1, 2'd3, 1'b1, 8'h44, 1'b1, 4'h8};
    vt[8]  = '{4'hF, 4'hF, 32'h44332211, 1'b1, 1'b0, 2'd3, 1'b0, 8'h00, 1'b0, 4'h0};
    vt[9]  = '{4'hF, 4'hF, 32'h44332211, 1'b1, 1'b1, 2'd0, 1'b1, 8'h11, 1'b1, 4'h1};
    vt[10] = '{4'hF, 4'hF, 32'h44332211, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 4'h0};

    // Reset priority and round-robin order with single-beat packets.
    do_reset();
    for (int i = 0; i < 11; i++) begin
      cyc(vt[i].rv, vt[i].rl, vt[i].rd, vt[i].ordy);
      chk($sformatf("rr_busy[%0d]", i), 32'(busy), 32'(vt[i].ebusy));
      chk($sformatf("rr_gid[%0d]", i), 32'(grant_id), 32'(vt[i].egid));
      chk($sformatf("rr_ov[%0d]", i), 32'(bus.out_valid), 32'(vt[i].eov));
      chk($sformatf("rr_od[%0d]", i), 32'(bus.out_data), 32'(vt[i].eod));
      chk($sformatf("rr_ol[%0d]", i), 32'(bus.out_last), 32'(vt[i].eol));
      chk($sformatf("rr_rdy[%0d]", i), 32'(bus.req_ready), 32'(vt[i].err));
    end

    // Packet hold: requester 2 keeps the channel for 3 beats while 1 waits.
    do_reset();
    cyc(4'b0100, 4'b0000, 32'h00A10000, 1'b1);
    chk("hold_arb_busy", 32'(busy), 32'h0);
    cyc(4'b0110, 4'b0000, 32'h00A1B100, 1'b1);
    chk("hold_gid", 32'(grant_id), 32'h2);
    chk("hold_d1", 32'(bus.out_data), 32'hA1);
    chk("hold_rdy1", 32'(bus.req_ready), 32'h4);
    cyc(4'b0110, 4'b0000, 32'h00A2B100, 1'b1);
    chk("hold_d2", 32'(bus.out_data), 32'hA2);
    chk("hold_rdy2", 32'(bus.req_ready), 32'h4);
    cyc(4'b0110, 4'b0100, 32'h00A3B100, 1'b1);
    chk("hold_d3", 32'(bus.out_data), 32'hA3);
    chk("hold_last", 32'(bus.out_last), 32'h1);
    chk("hold_rdy3", 32'(bus.req_ready), 32'h4);
    cyc(4'b0010, 4'b0000, 32'h0000B100, 1'b1);
    chk("hold_bubble_busy", 32'(busy), 32'h0);
    chk("hold_bubble_rdy", 32'(bus.req_ready), 32'h0);
    cyc(4'b0010, 4'b0000, 32'h0000B100, 1'b1);
    chk("hold_next_gid", 32'(grant_id), 32'h1);
    chk("hold_next_busy", 32'(busy), 32'h1);
    chk("hold_next_od", 32'(bus.out_data), 32'hB1);

    // Burst limit: requester 0 streams 10 beats without last, 3 is valid.
    do_reset();
    n  = 0;
    ng = 0;
    for (int c = 0; c < 60 && ng < 12; c++) begin
      d0 = 8'h50 + 8'(n);
      cyc({1'b1, 2'b00, n < 10}, 4'b1000, {8'hF0, 16'h0, d0}, 1'b1);
      if (bus.out_valid && bus.out_ready) begin
        got_bg[ng] = grant_id;
        got_bd[ng] = bus.out_data;
        if (grant_id == 2'd0) n++;
        ng++;
      end
    end
    chk("burst_count", 32'(ng), 32'd12);
    for (int i = 0; i < ng; i++) begin
      chk($sformatf("burst_gid[%0d]", i), 32'(got_bg[i]), 32'(exp_bg[i]));
      chk($sformatf("burst_data[%0d]", i), 32'(got_bd[i]), 32'(exp_bd[i]));
    end

    // Backpressure: 5 stalled cycles must not count as beats.
    do_reset();
    cyc(4'b0010, 4'b0000, 32'h00007700, 1'b0);
    chk("bp_arb_busy", 32'(busy), 32'h0);
    for (int i = 0; i < 5; i++) begin
      cyc(4'b0010, 4'b0000, 32'h00007700, 1'b0);
      chk($sformatf("bp_ov[%0d]", i), 32'(bus.out_valid), 32'h1);
      chk($sformatf("bp_od[%0d]", i), 32'(bus.out_data), 32'h77);
      chk($sformatf("bp_rdy[%0d]", i), 32'(bus.req_ready), 32'h0);
      chk($sformatf("bp_busy[%0d]", i), 32'(busy), 32'h1);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(4'b0010, 4'b0000, 32'h00007700, 1'b1);
      chk($sformatf("bp_beat_busy[%0d]", i), 32'(busy), 32'h1);
      chk($sformatf("bp_beat_rdy[%0d]", i), 32'(bus.req_ready), 32'h2);
    end
    cyc(4'b0000, 4'b0000, 32'h0, 1'b1);
    chk("bp_release_after_4", 32'(busy), 32'h0);

    // Granted requester drops valid mid-packet; grant is held.
    do_reset();
    cyc(4'b0100, 4'b0000, 32'h00C10000, 1'b1);
    chk("gap_arb_busy", 32'(busy), 32'h0);
    cyc(4'b0100, 4'b0000, 32'h00C10000, 1'b1);
    chk("gap_first_od", 32'(bus.out_data), 32'hC1);
    for (int i = 0; i < 3; i++) begin
      cyc(4'b1011, 4'b0000, 32'h11000000, 1'b1);
      chk($sformatf("gap_busy[%0d]", i), 32'(busy), 32'h1);
      chk($sformatf("gap_gid[%0d]", i), 32'(grant_id), 32'h2);
      chk($sformatf("gap_ov[%0d]", i), 32'(bus.out_valid), 32'h0);
      chk($sformatf("gap_rdy[%0d]", i), 32'(bus.req_ready), 32'h4);
    end
    cyc(4'b1111, 4'b0100, 32'h11C20000, 1'b1);
    chk("gap_resume_od", 32'(bus.out_data), 32'hC2);
    chk("gap_resume_ol", 32'(bus.out_last), 32'h1);
    cyc(4'b1011, 4'b0000, 32'h11000000, 1'b1);
    chk("gap_bubble_busy", 32'(busy), 32'h0);
    cyc(4'b1011, 4'b0000, 32'h11000000, 1'b1);
    chk("gap_next_gid", 32'(grant_id), 32'h3);

    // Reset during beat 2 of a 4-beat packet.
    do_reset();
    cyc(4'b0010, 4'b0000, 32'h00003100, 1'b1);
    cyc(4'b0010, 4'b0000, 32'h00003100, 1'b1);
    chk("mrst_beat1", 32'(bus.out_data), 32'h31);
    cyc(4'b0010, 4'b0000, 32'h00003200, 1'b1);
    chk("mrst_beat2_ov", 32'(bus.out_valid), 32'h1);
    rst = 1'b1;
    #1;
    chk("mrst_ov", 32'(bus.out_valid), 32'h0);
    chk("mrst_rdy", 32'(bus.req_ready), 32'h0);
    chk("mrst_busy", 32'(busy), 32'h0);
    chk("mrst_gid", 32'(grant_id), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(4'b1110, 4'b0000, 32'h00003300, 1'b1);
    #1;
    chk("mrst_after_busy", 32'(busy), 32'h0);
    cyc(4'b1110, 4'b0000, 32'h00003300, 1'b1);
    chk("mrst_regrant_gid", 32'(grant_id), 32'h1);
    chk("mrst_regrant_busy", 32'(busy), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
